// File: rtl/router_pkg.sv
// Shared types and constants for the router packet transmitter.
package router_pkg;

  localparam int unsigned MAX_LEN      = 63;
  localparam int unsigned BUF_DEPTH    = MAX_LEN + 1;
  localparam logic [1:0]  ADDR_INVALID = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StHdr,
    StPld,
    StPar,
    StChk
  } tx_state_e;

  typedef struct packed {
    logic [5:0] len;
    logic [1:0] addr;
  } hdr_t;

endpackage

// File: rtl/router_pkt_tx_if.sv
// Command, payload-load and router-side signals of the packet transmitter.
interface router_pkt_tx_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_addr;
  logic [5:0]  cmd_len;
  logic        cmd_bad_par;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_data;
  logic        busy;
  logic        error;
  logic [7:0]  data_in;
  logic        pkt_valid;
  logic        tx_done;
  logic        tx_err;
  logic [15:0] pkt_count;

  // Transmitter side
  modport master (
    input  cmd_valid, cmd_addr, cmd_len, cmd_bad_par, wr_valid, wr_data, busy, error,
    output cmd_ready, wr_ready, data_in, pkt_valid, tx_done, tx_err, pkt_count
  );

  // Command source / router side
  modport slave (
    output cmd_valid, cmd_addr, cmd_len, cmd_bad_par, wr_valid, wr_data, busy, error,
    input  cmd_ready, wr_ready, data_in, pkt_valid, tx_done, tx_err, pkt_count
  );

endinterface

// File: rtl/router_pkt_buf.sv
// Payload buffer: single-port register array, synchronous write, asynchronous read, no reset.
module router_pkt_buf
  import router_pkg::*;
(
  input  logic       clock,
  input  logic       we,
  input  logic [5:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] mem_q [BUF_DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter for the router 1x3 source port: buffers a payload, sends header,
// payload and parity under busy back-pressure, then watches router error for ERR_WIN cycles.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int unsigned ERR_WIN = 3
) (
  input logic             clock,
  input logic             reset,
  router_pkt_tx_if.master bus
);

  localparam int unsigned    CntW    = (ERR_WIN > 1) ? $clog2(ERR_WIN) : 1;
  localparam logic [CntW-1:0] ChkLast = CntW'(ERR_WIN - 1);

  tx_state_e       state_q, state_d;
  logic [5:0]      idx_q, idx_d;
  logic [7:0]      par_q, par_d;
  hdr_t            hdr_q, hdr_d;
  logic            bad_q, bad_d;
  logic            flag_q, flag_d;
  logic [CntW-1:0] chk_cnt_q, chk_cnt_d;
  logic [7:0]      data_in_q, data_in_d;
  logic            pkt_valid_q, pkt_valid_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            wr_ready_q, wr_ready_d;
  logic            tx_done_q, tx_done_d;
  logic            tx_err_q, tx_err_d;
  logic [15:0]     pkt_count_q, pkt_count_d;

  hdr_t       cmd_hdr;
  logic       buf_we;
  logic [5:0] buf_addr;
  logic [7:0] buf_rdata;

  assign cmd_hdr = '{len: bus.cmd_len, addr: bus.cmd_addr};
  assign buf_we  = (state_q == StLoad) && bus.wr_valid;

  // Read address anticipates the byte registered onto data_in at the next transfer edge.
  always_comb begin
    unique case (state_q)
      StLoad:  buf_addr = idx_q;
      StPld:   buf_addr = idx_q + 6'd1;
      default: buf_addr = 6'd0;
    endcase
  end

  router_pkt_buf u_buf (
    .clock (clock),
    .we    (buf_we),
    .addr  (buf_addr),
    .wdata (bus.wr_data),
    .rdata (buf_rdata)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    par_d       = par_q;
    hdr_d       = hdr_q;
    bad_d       = bad_q;
    flag_d      = flag_q;
    chk_cnt_d   = chk_cnt_q;
    data_in_d   = 8'h00;
    pkt_valid_d = 1'b0;
    cmd_ready_d = 1'b0;
    wr_ready_d  = 1'b0;
    tx_done_d   = 1'b0;
    tx_err_d    = 1'b0;
    pkt_count_d = pkt_count_q;

    unique case (state_q)
      StIdle: begin
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid && cmd_ready_q) begin
          if (bus.cmd_len == 6'd0) begin
            tx_done_d = 1'b1;
            tx_err_d  = 1'b1;
          end else begin
            state_d     = StLoad;
            cmd_ready_d = 1'b0;
            wr_ready_d  = 1'b1;
            hdr_d       = cmd_hdr;
            bad_d       = bus.cmd_bad_par;
            idx_d       = 6'd0;
            par_d       = cmd_hdr;
          end
        end
      end

      StLoad: begin
        wr_ready_d = 1'b1;
        if (bus.wr_valid) begin
          par_d = par_q ^ bus.wr_data;
          idx_d = idx_q + 6'd1;
          if (idx_q == hdr_q.len - 6'd1) begin
            state_d     = StHdr;
            wr_ready_d  = 1'b0;
            data_in_d   = hdr_q;
            pkt_valid_d = 1'b1;
          end
        end
      end

      StHdr: begin
        pkt_valid_d = 1'b1;
        if (bus.busy) begin
          data_in_d = data_in_q;
        end else begin
          state_d   = StPld;
          idx_d     = 6'd0;
          data_in_d = buf_rdata;
        end
      end

      StPld: begin
        pkt_valid_d = 1'b1;
        if (bus.busy) begin
          data_in_d = data_in_q;
        end else if (idx_q == hdr_q.len - 6'd1) begin
          state_d     = StPar;
          pkt_valid_d = 1'b0;
          data_in_d   = par_q ^ {7'b0, bad_q};
        end else begin
          idx_d     = idx_q + 6'd1;
          data_in_d = buf_rdata;
        end
      end

      StPar: begin
        if (bus.busy) begin
          data_in_d = data_in_q;
        end else begin
          state_d   = StChk;
          chk_cnt_d = '0;
          flag_d    = 1'b0;
        end
      end

      StChk: begin
        flag_d = flag_q | bus.error;
        if (chk_cnt_q == ChkLast) begin
          state_d     = StIdle;
          cmd_ready_d = 1'b1;
          tx_done_d   = 1'b1;
          tx_err_d    = flag_q | bus.error;
          pkt_count_d = pkt_count_q + 16'd1;
        end else begin
          chk_cnt_d = chk_cnt_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= 6'd0;
      par_q       <= 8'h00;
      hdr_q       <= '0;
      bad_q       <= 1'b0;
      flag_q      <= 1'b0;
      chk_cnt_q   <= '0;
      data_in_q   <= 8'h00;
      pkt_valid_q <= 1'b0;
      cmd_ready_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      tx_done_q   <= 1'b0;
      tx_err_q    <= 1'b0;
      pkt_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      par_q       <= par_d;
      hdr_q       <= hdr_d;
      bad_q       <= bad_d;
      flag_q      <= flag_d;
      chk_cnt_q   <= chk_cnt_d;
      data_in_q   <= data_in_d;
      pkt_valid_q <= pkt_valid_d;
      cmd_ready_q <= cmd_ready_d;
      wr_ready_q  <= wr_ready_d;
      tx_done_q   <= tx_done_d;
      tx_err_q    <= tx_err_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign bus.data_in   = data_in_q;
  assign bus.pkt_valid = pkt_valid_q;
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.wr_ready  = wr_ready_q;
  assign bus.tx_done   = tx_done_q;
  assign bus.tx_err    = tx_err_q;
  assign bus.pkt_count = pkt_count_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: table of packets plus illegal-length and reset sequences.
module tb_router_pkt_tx;
  import router_pkg::*;

  localparam int unsigned ErrWin = 3;

  typedef struct {
    logic [1:0] addr;
    logic [5:0] len;
    logic       bad;
    logic [7:0] base;
    int         stall_at;
    int         stall_n;
    int         err_at;
    logic [7:0] exp_hdr;
    logic [7:0] exp_par;
    logic       exp_err;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_cnt = 0;
  vec_t vecs [6];

  router_pkt_tx_if bus ();

  router_pkt_tx #(
    .ERR_WIN (ErrWin)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue_cmd(input logic [1:0] addr, input logic [5:0] len, input logic bad);
    for (int i = 0; i < 50 && !bus.cmd_ready; i++) tick();
    check("cmd_ready_before_cmd", {31'b0, bus.cmd_ready}, 1);
    bus.cmd_valid   = 1'b1;
    bus.cmd_addr    = addr;
    bus.cmd_len     = len;
    bus.cmd_bad_par = bad;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic load(input logic [5:0] len, input logic [7:0] base);
    check("wr_ready_in_load", {31'b0, bus.wr_ready}, 1);
    for (int i = 0; i < int'(len); i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = base + 8'(i);
      tick();
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic xmit(input vec_t v);
    logic [7:0] exp_b [0:65];
    int n, cyc, stall, done_j;
    logic [7:0] d;
    logic pv;

    exp_b[0] = v.exp_hdr;
    for (int i = 0; i < int'(v.len); i++) exp_b[i+1] = v.base + 8'(i);
    exp_b[int'(v.len)+1] = v.exp_par;

    issue_cmd(v.addr, v.len, v.bad);
    load(v.len, v.base);

    n = 0;
    cyc = 0;
    stall = v.stall_n;
    while (n < int'(v.len) + 2 && cyc < 300) begin
      bus.busy = (n == v.stall_at) && (stall > 0);
      @(negedge clock);
      d  = bus.data_in;
      pv = bus.pkt_valid;
      check($sformatf("byte[%0d]", n), {24'b0, d}, {24'b0, exp_b[n]});
      check($sformatf("pkt_valid[%0d]", n), {31'b0, pv}, {31'b0, (n <= int'(v.len))});
      @(posedge clock);
      #1;
      if (bus.busy) stall--;
      else n++;
      cyc++;
    end
    bus.busy = 1'b0;
    check("pkt_cycles", cyc, int'(v.len) + 2 + v.stall_n);

    // Router error model: raise error for the edge Tp+err_at after the parity transfer edge Tp.
    done_j = 0;
    for (int j = 1; j <= int'(ErrWin) + 4; j++) begin
      bus.error = (j == v.err_at);
      tick();
      bus.error = 1'b0;
      @(negedge clock);
      if (bus.tx_done) begin
        done_j = j;
        break;
      end
    end
    exp_cnt++;
    check("tx_done_latency", done_j, ErrWin);
    check("tx_err", {31'b0, bus.tx_err}, {31'b0, v.exp_err});
    check("pkt_count", {16'b0, bus.pkt_count}, exp_cnt);
    check("pkt_valid_chk", {31'b0, bus.pkt_valid}, 0);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("tx_done_pulse", {31'b0, bus.tx_done}, 0);
    check("cmd_ready_after", {31'b0, bus.cmd_ready}, 1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0] p;
    logic       seen;

    bus.cmd_valid   = 1'b0;
    bus.cmd_addr    = 2'd0;
    bus.cmd_len     = 6'd0;
    bus.cmd_bad_par = 1'b0;
    bus.wr_valid    = 1'b0;
    bus.wr_data     = 8'h00;
    bus.busy        = 1'b0;
    bus.error       = 1'b0;

    p = 8'hFE;
    for (int i = 0; i < 63; i++) p ^= 8'(i);
    //         addr  len    bad   base   st  sn  err hdr    par     err
    vecs[0] = '{2'd1, 6'd4,  1'b0, 8'h01, -1, 0,  0, 8'h11, 8'h15, 1'b0};
    vecs[1] = '{2'd1, 6'd4,  1'b0, 8'h01,  2, 3,  0, 8'h11, 8'h15, 1'b0};
    vecs[2] = '{2'd1, 6'd4,  1'b1, 8'h01, -1, 0,  2, 8'h11, 8'h14, 1'b1};
    vecs[3] = '{2'd2, 6'd63, 1'b0, 8'h00, -1, 0,  0, 8'hFE, p,     1'b0};
    vecs[4] = '{ADDR_INVALID, 6'd1, 1'b0, 8'hA5, -1, 0, 3, 8'h07, 8'hA2, 1'b1};
    vecs[5] = '{2'd0, 6'd2,  1'b0, 8'h80,  0, 2,  0, 8'h08, 8'h09, 1'b0};

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_data_in", {24'b0, bus.data_in}, 0);
    check("rst_pkt_valid", {31'b0, bus.pkt_valid}, 0);
    check("rst_cmd_ready", {31'b0, bus.cmd_ready}, 0);
    check("rst_wr_ready", {31'b0, bus.wr_ready}, 0);
    check("rst_tx_done", {31'b0, bus.tx_done}, 0);
    check("rst_tx_err", {31'b0, bus.tx_err}, 0);
    check("rst_pkt_count", {16'b0, bus.pkt_count}, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick();
    @(negedge clock);
    check("idle_cmd_ready", {31'b0, bus.cmd_ready}, 1);
    @(posedge clock);
    #1;

    for (int k = 0; k < 6; k++) xmit(vecs[k]);

    // Illegal zero length: done/err pulse next cycle, no bus activity, count unchanged.
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 2'd1;
    bus.cmd_len   = 6'd0;
    tick();
    bus.cmd_valid = 1'b0;
    @(negedge clock);
    check("zlen_tx_done", {31'b0, bus.tx_done}, 1);
    check("zlen_tx_err", {31'b0, bus.tx_err}, 1);
    check("zlen_pkt_valid", {31'b0, bus.pkt_valid}, 0);
    @(posedge clock);
    #1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      seen |= bus.pkt_valid | bus.wr_ready | bus.tx_done;
      @(posedge clock);
      #1;
    end
    check("zlen_quiet", {31'b0, seen}, 0);
    check("zlen_pkt_count", {16'b0, bus.pkt_count}, exp_cnt);

    // Reset in the cycle after the 2nd payload byte transfers.
    issue_cmd(2'd1, 6'd4, 1'b0);
    load(6'd4, 8'h01);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    @(negedge clock);
    check("mid_rst_pkt_valid", {31'b0, bus.pkt_valid}, 0);
    check("mid_rst_data_in", {24'b0, bus.data_in}, 0);
    check("mid_rst_cmd_ready", {31'b0, bus.cmd_ready}, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      seen |= bus.pkt_valid | bus.tx_done;
      @(posedge clock);
      #1;
    end
    check("mid_rst_no_done", {31'b0, seen}, 0);
    check("mid_rst_cmd_ready_after", {31'b0, bus.cmd_ready}, 1);
    exp_cnt = 0;
    check("mid_rst_pkt_count", {16'b0, bus.pkt_count}, exp_cnt);
    xmit(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Synthesizable packet transmitter that drives the router 1x3 source port (`data_in`, `pkt_valid`) and obeys the router's `busy` back-pressure. It takes a command (destination address and payload length), buffers the payload, and emits header, payload and parity bytes in router packet format. It then watches the router's `error` output to report whether the packet was accepted cleanly. It sits in front of the router as an on-chip traffic source and as a self-checking stimulus block.

## Interface
- `ERR_WIN`, default 3: number of cycles after the parity byte during which router `error` is sampled.
- `clock` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_addr` in 2: destination port, 0..2. A value of 3 is transmitted unchanged and dropped by the router.
- `cmd_len` in 6: payload length, 1..63. A value of 0 is illegal.
- `cmd_bad_par` in 1: invert bit 0 of the parity byte (error injection).
- `wr_valid` in 1, `wr_ready` out 1, `wr_data` in 8: payload load handshake.
- `busy` in 1: router back-pressure.
- `error` in 1: router parity-error flag.
- `data_in` out 8: byte to the router.
- `pkt_valid` out 1: high for the header and payload bytes, low for the parity byte.
- `tx_done` out 1: one-cycle pulse at packet completion.
- `tx_err` out 1: one-cycle pulse, coincident with `tx_done`, when the packet failed.
- `pkt_count` out 16: count of completed packets; wraps from 0xFFFF to 0.

## Operation
- **States:** IDLE, LOAD, HDR, PLD, PAR, CHK.
- **IDLE:**
  - `cmd_ready`=1.
  - On `cmd_valid`, capture addr, len and bad_par, then go to LOAD.
  - If `cmd_len`==0: stay in IDLE, pulse `tx_done` and `tx_err` next cycle, and produce no bus activity.
- **LOAD:**
  - `wr_ready`=1.
  - Each `wr_valid` beat writes `buf[idx]` and updates parity: `par ^= wr_data`.
  - Parity is preset to the header byte on command accept.
  - The write that makes idx==len goes to HDR.
- **HDR:** `data_in` = {len, addr}, `pkt_valid`=1.
- **PLD:** `data_in` = `buf[idx]`, `pkt_valid`=1. After the byte at idx==len-1 transfers, go to PAR.
- **PAR:** `data_in` = par ^ {7'b0, bad_par}, `pkt_valid`=0.
- **Byte transfer rule (HDR, PLD, PAR):** a byte transfers on a rising edge where `busy`==0. While `busy`==1, `data_in` and `pkt_valid` hold.
- **CHK:**
  - Runs for exactly ERR_WIN cycles after the parity byte transfers.
  - `error`==1 on any sampled edge sets an internal flag.
  - At the end: pulse `tx_done`, pulse `tx_err`=flag, increment `pkt_count`, return to IDLE.
- **Output values outside HDR/PLD/PAR:** `pkt_valid`=0 and `data_in`=0.
- **Ready outputs:** `cmd_ready` is 0 outside IDLE; `wr_ready` is 0 outside LOAD.
- **Buffer:** 64 entries × 8 bits.
- **idx:** a 6-bit counter, reset to 0 on command accept and on the HDR→PLD transition.

## Timing
- All outputs are registered.
- **Reset values:** `data_in`=0x00, `pkt_valid`=0, `cmd_ready`=0 during reset, then 1 in IDLE; `wr_ready`=0, `tx_done`=0, `tx_err`=0, `pkt_count`=0. State goes to IDLE. Buffer contents are not cleared.
- **Command to LOAD:** command accept at edge T0 puts the block in LOAD, with `wr_ready`=1 from T0+1.
- **LOAD to header:** the last write at edge Tl makes the header visible on `data_in` with `pkt_valid`=1 from Tl+1.
- **Throughput:** with `busy`==0 throughout, the header, len payload bytes and the parity byte occupy len+2 consecutive cycles.
- **Parity to completion:** `pkt_valid` falls together with the parity byte appearing. `tx_done` asserts ERR_WIN+1 cycles after the parity transfer edge.
- **Next command:** a new command is accepted no earlier than the cycle after `tx_done`.
- **Reset mid-packet:** the next edge forces `pkt_valid`=0 and IDLE. No parity byte is sent, and `tx_done` does not pulse.
- **`busy` asserted while in CHK:** ignored.
- **`wr_valid` outside LOAD:** ignored.

## Structure
- Shared package `router_pkg` holds:
  - `tx_state_e` enum.
  - `hdr_t` packed struct {len[5:0], addr[1:0]}.
  - Constants `MAX_LEN`=63 and `ADDR_INVALID`=2'd3.
- One sub-module, `router_pkt_buf`: 64×8 single-port register array with synchronous write and asynchronous read. It contains no reset.

## Test plan
- **Basic packet:** addr=1, len=4, payload 01 02 03 04, `busy`=0 → `data_in` sequence 0x11, 01, 02, 03, 04, 0x15 on consecutive cycles; `pkt_valid` is 1 for 5 cycles then 0 on the 0x15 byte; `tx_done` pulses with `tx_err`=0; `pkt_count`=1.
- **Back-pressure:** same packet with `busy`=1 for 3 cycles during payload byte 02 → 02 is held for 4 cycles, all byte values are unchanged, and the total length grows by 3 cycles.
- **Error injection:** `cmd_bad_par`=1 → parity byte 0x14. When the router model raises `error` inside the window, `tx_err`=1 with `tx_done`.
- **Maximum length:** len=63 with payload 0x00..0x3E to addr 2 → header 0xFE and 65 bytes transferred. Parity = 0xFE ^ XOR(0x00..0x3E); the bench computes this reference value.
- **Illegal length:** `cmd_len`=0 → `tx_done` and `tx_err` pulse the next cycle, `pkt_valid` never rises, and `pkt_count` is unchanged.
- **Reset mid-packet:** `reset` asserted in the cycle after the 2nd payload byte → `pkt_valid`=0 and `cmd_ready`=1 afterwards, no `tx_done`, and the next packet sends correctly.
